// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select (JALR > JAL > branch > +4), stall, retire counter.
// Define PC_ALIGN_CHECK_EN to enable the misaligned-target trap and the RUN/HALT FSM.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jal,
  input  logic [XLEN-1:0]  jal_offset,
  input  logic             jalr,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  jalr_imm,
  input  logic             resume,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             halted,
  output logic [XLEN-1:0]  trap_pc,
  output logic [XLEN-1:0]  trap_addr,
  output logic [CNT_W-1:0] retired
);

  // No valid/ready handshake: every control input is level-sampled on each rising edge.
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  jalr_sum, raw_target;
  logic [CNT_W-1:0] retired_q;
  logic             ctrl, retire;

  assign jalr_sum = rs1 + jalr_imm;
  assign ctrl     = jalr | jal | branch_taken;

  always_comb begin
    raw_target = pc_q + branch_offset;
    if (jalr)
      raw_target = jalr_sum & ~XLEN'(1);
    else if (jal)
      raw_target = pc_q + jal_offset;
  end

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d, trap_addr_q, trap_addr_d;

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    trap_pc_d   = trap_pc_q;
    trap_addr_d = trap_addr_q;
    retire      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!stall) begin
          retire = 1'b1;
          if (ctrl && (raw_target[1:0] != 2'b00)) begin
            // Faulting instruction still retires; fetch freezes at its PC.
            state_d     = S_HALT;
            trap_pc_d   = pc_q;
            trap_addr_d = raw_target;
          end else if (ctrl) begin
            pc_d = raw_target;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_d    = TRAP_VECTOR;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      trap_pc_q   <= '0;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_pc_q   <= trap_pc_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign halted    = (state_q == S_HALT);
  assign trap_pc   = trap_pc_q;
  assign trap_addr = trap_addr_q;
`else
  logic unused_ok;

  // Without the check, targets are silently aligned to a word and the unit never halts.
  always_comb begin
    pc_d   = pc_q;
    retire = 1'b0;
    if (!stall) begin
      retire = 1'b1;
      pc_d   = ctrl ? (raw_target & ~XLEN'(3)) : (pc_q + XLEN'(4));
    end
  end

  assign unused_ok = ^{resume, TRAP_VECTOR};
  assign halted    = 1'b0;
  assign trap_pc   = '0;
  assign trap_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      retired_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed cases plus random traffic, scored against a spec-level PC model.
module tb_pc_unit;
  localparam int XLEN = 32;
  localparam int EW   = 3 * XLEN + 1 + 32;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, stall, branch_taken, jal, jalr, resume;
  logic [XLEN-1:0] branch_offset, jal_offset, rs1, jalr_imm;
  logic [XLEN-1:0] pc_out, pc_plus4, trap_pc, trap_addr;
  logic            halted;
  logic [31:0]     retired;

  logic [EW-1:0] exp_q[$];
  int            total = 0;
  int            bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_tpc, m_taddr, m_ret;
  logic        m_halt;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jal(jal), .jal_offset(jal_offset),
    .jalr(jalr), .rs1(rs1), .jalr_imm(jalr_imm),
    .resume(resume),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .halted(halted),
    .trap_pc(trap_pc), .trap_addr(trap_addr), .retired(retired)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, advance the model, queue the expected post-edge state
  task automatic drive(input bit r, input bit st, input bit bt, input logic [31:0] bo,
                       input bit jl, input logic [31:0] jo, input bit jr,
                       input logic [31:0] a, input logic [31:0] im, input bit rs);
    logic [31:0] t;
    bit          req;
    @(negedge clk);
    rst = r; stall = st; branch_taken = bt; branch_offset = bo;
    jal = jl; jal_offset = jo; jalr = jr; rs1 = a; jalr_imm = im; resume = rs;
    if (r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_tpc = 32'h0; m_taddr = 32'h0; m_ret = 32'h0;
    end else if (m_halt) begin
      if (rs) begin
        m_pc   = 32'h100;
        m_halt = 1'b0;
      end
    end else if (!st) begin
      m_ret = m_ret + 1;
      req   = jr || jl || bt;
      if (jr) begin
        t = a + im;
        t = t - (t % 2);
      end else if (jl) t = m_pc + jo;
      else             t = m_pc + bo;
      if (!req)
        m_pc = m_pc + 4;
      else if (ALIGN && (t % 4 != 0)) begin
        m_tpc   = m_pc;
        m_taddr = t;
        m_halt  = 1'b1;
      end else
        m_pc = t - (t % 4);
    end
    exp_q.push_back({m_pc, m_tpc, m_taddr, m_halt, m_ret});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_pc(input logic [31:0] addr);
    drive(0, 0, 0, 0, 1, addr - m_pc, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor / scoreboard: one expected entry per clock edge that the driver covered
  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc_out",    pc_out,            e[128:97]);
      check("pc_plus4",  pc_plus4,          e[128:97] + 32'd4);
      check("trap_pc",   trap_pc,           e[96:65]);
      check("trap_addr", trap_addr,         e[64:33]);
      check("halted",    {31'b0, halted},   {31'b0, e[32]});
      check("retired",   retired,           e[31:0]);
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0; resume = 1'b0;
    branch_offset = '0; jal_offset = '0; rs1 = '0; jalr_imm = '0;
    m_pc = '0; m_tpc = '0; m_taddr = '0; m_ret = '0; m_halt = 1'b0;

    // Reset then free run
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();

    // Branch / JAL / JALR / all-three from 0x40
    goto_pc(32'h40); drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
    goto_pc(32'h40); drive(0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    goto_pc(32'h40); drive(0, 0, 0, 0, 0, 0, 1, 32'h101, 32'h3, 0);
    goto_pc(32'h40); drive(0, 0, 1, 32'hFFFF_FFF8, 1, 32'h10, 1, 32'h101, 32'h3, 0);

    // Stall holds PC and retire count, then the JAL goes through
    goto_pc(32'h20);
    repeat (3) drive(0, 1, 0, 0, 1, 32'h30, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h30, 0, 0, 0, 0);

    // Misaligned JALR: trap (checked build) or forced alignment
    goto_pc(32'h80); drive(0, 0, 0, 0, 0, 0, 1, 32'h202, 32'h0, 0);
    idle();
    drive(0, 1, 1, 32'h8, 1, 32'h8, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Sequential wrap at the top of the address space
    goto_pc(32'hFFFF_FFFC); idle(); idle();

    // Reset overrides a resume while halted
    goto_pc(32'h80); drive(0, 0, 0, 0, 0, 0, 1, 32'h202, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bo, jo, a, im;
      bo = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      jo = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      a  = $urandom;
      im = $urandom_range(0, 15);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, bo, $urandom_range(0, 3) == 0, jo,
            $urandom_range(0, 3) == 0, a, im, $urandom_range(0, 2) == 0);
    end

    // Drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
